module_svf_multi: RTL and testbench

//  Time-multiplexed multi-channel state-variable filter (Chamberlin SVF), NCH channels, one shared multiplier.
//  Per-channel mode (LP/BP/HP/notch), cutoff f and damping q are set by MIDI CC.

---
 rtl/module_svf_multi.sv | 231 +++++++++++++++++++++++
 tb/tb_module_svf_multi.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_svf_multi.sv
// Time-multiplexed Chamberlin state-variable filter: NCH channels share one multiplier,
// per-channel mode/cutoff/damping set over MIDI CC and slewed once per frame.
`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 4
`endif
`ifndef MIDI_CMD_CC
`define MIDI_CMD_CC 4'hB
`endif

module module_svf_multi #(
  parameter int         DATA_W       = 18,
  parameter int         NCH          = 2,
  parameter logic [3:0] MIDI_CHANNEL = 4'h0,
  parameter logic [6:0] F_CC_BASE    = 7'd16,
  parameter logic [6:0] Q_CC_BASE    = 7'd24,
  parameter logic [6:0] MODE_CC_BASE = 7'd32,
  parameter int         SLEW_STEP    = 256,
  parameter int         Q_MIN        = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      midi_rdy,
  input  logic [`MIDI_CMD_SIZE-1:0] midi_cmd,
  input  logic [3:0]                midi_ch_sysn,
  input  logic [6:0]                midi_data0,
  input  logic [6:0]                midi_data1,
  input  logic                      sample_in_rdy,
  input  logic [NCH*DATA_W-1:0]     sample_in,
  output logic                      sample_out_rdy,
  output logic [NCH*DATA_W-1:0]     sample_out,
  output logic                      busy,
  output logic                      err_overflow
);

  // Strobes: sample_in_rdy is a one-cycle valid taken only while idle (busy=0), a frame
  // offered while busy is dropped; sample_out_rdy is a one-cycle valid with no ready.
  localparam int SW = DATA_W + 2;
  localparam int PW = 2 * DATA_W + 1;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  typedef logic signed [DATA_W-1:0] smp_t;
  typedef logic [DATA_W-1:0]        coef_t;
  typedef enum logic [2:0] {IDLE, LOAD, MUL_LP, MUL_Q, MUL_BP, WB, DONE} state_t;

  localparam coef_t STEP    = coef_t'(SLEW_STEP);
  localparam coef_t Q_MIN_C = coef_t'(Q_MIN);
  localparam logic signed [SW-1:0] S_MAX = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] S_MIN = {3'b111, {(DATA_W-1){1'b0}}};

  state_t        state;
  logic [CW-1:0] ch;
  smp_t          x_lat    [NCH];
  smp_t          lp       [NCH];
  smp_t          bp       [NCH];
  smp_t          out_buf  [NCH];
  coef_t         f_tgt    [NCH];
  coef_t         f_act    [NCH];
  coef_t         q_tgt    [NCH];
  coef_t         q_act    [NCH];
  logic [1:0]    mode_tgt [NCH];
  logic [1:0]    mode_act [NCH];
  smp_t          lp_n, bp_n, hp;
  logic          ovf;

  function automatic logic signed [SW-1:0] ext(input smp_t v);
    return SW'(v);
  endfunction

  function automatic smp_t sat(input logic signed [SW-1:0] v);
    if (v > S_MAX) return S_MAX[DATA_W-1:0];
    if (v < S_MIN) return S_MIN[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  function automatic coef_t slew(input coef_t act, input coef_t tgt);
    if (tgt > act) return (tgt - act > STEP) ? act + STEP : tgt;
    return (act - tgt > STEP) ? act - STEP : tgt;
  endfunction

  function automatic logic in_range(input logic [6:0] d, input logic [6:0] base);
    return ({1'b0, d} >= {1'b0, base}) && ({1'b0, d} < {1'b0, base} + 8'(NCH));
  endfunction

  // Shared multiplier: bp*f for MUL_LP, bp*q for MUL_Q, hp*f for MUL_BP.
  smp_t                  mul_a;
  coef_t                 mul_b;
  logic signed [PW-1:0]  a_ext, b_ext, prod;
  logic signed [SW-1:0]  prod_s, sum;
  smp_t                  sum_sat;
  logic                  sum_ovf;

  always_comb begin
    mul_a = bp[ch];
    mul_b = f_act[ch];
    if (state == MUL_Q) mul_b = q_act[ch];
    else if (state == MUL_BP) mul_a = hp;
  end

  assign a_ext  = PW'(mul_a);
  assign b_ext  = PW'($signed({1'b0, mul_b}));
  assign prod   = a_ext * b_ext;
  assign prod_s = SW'(prod >>> (DATA_W - 1));

  always_comb begin
    sum = '0;
    case (state)
      MUL_LP:  sum = ext(lp[ch]) + prod_s;
      MUL_Q:   sum = ext(x_lat[ch]) - ext(lp_n) - prod_s;
      MUL_BP:  sum = ext(bp[ch]) + prod_s;
      default: sum = ext(hp) + ext(lp_n);
    endcase
  end

  assign sum_sat = sat(sum);
  assign sum_ovf = (sum > S_MAX) || (sum < S_MIN);

  // MIDI CC decode: only targets move here, the running frame is untouched.
  logic  cc_ev, f_hit, q_hit, m_hit;
  coef_t f_val, q_raw, q_val;

  assign cc_ev = midi_rdy && (midi_cmd == `MIDI_CMD_CC) && (midi_ch_sysn == MIDI_CHANNEL);
  assign f_hit = in_range(midi_data0, F_CC_BASE);
  assign q_hit = in_range(midi_data0, Q_CC_BASE);
  assign m_hit = in_range(midi_data0, MODE_CC_BASE);
  assign f_val = coef_t'(midi_data1) << (DATA_W - 9);
  assign q_raw = coef_t'(midi_data1) << (DATA_W - 8);
  assign q_val = (q_raw < Q_MIN_C) ? Q_MIN_C : q_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        f_tgt[c]    <= '0;
        q_tgt[c]    <= Q_MIN_C;
        mode_tgt[c] <= 2'd0;
      end
    end else if (cc_ev) begin
      if (f_hit) f_tgt[CW'(midi_data0 - F_CC_BASE)] <= f_val;
      if (q_hit) q_tgt[CW'(midi_data0 - Q_CC_BASE)] <= q_val;
      if (m_hit) mode_tgt[CW'(midi_data0 - MODE_CC_BASE)] <= midi_data1[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      ch             <= '0;
      lp_n           <= '0;
      bp_n           <= '0;
      hp             <= '0;
      ovf            <= 1'b0;
      busy           <= 1'b0;
      sample_out_rdy <= 1'b0;
      sample_out     <= '0;
      err_overflow   <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        x_lat[c]    <= '0;
        lp[c]       <= '0;
        bp[c]       <= '0;
        out_buf[c]  <= '0;
        f_act[c]    <= '0;
        q_act[c]    <= Q_MIN_C;
        mode_act[c] <= 2'd0;
      end
    end else begin
      sample_out_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_in_rdy) begin
            for (int c = 0; c < NCH; c++) x_lat[c] <= sample_in[c*DATA_W +: DATA_W];
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          for (int c = 0; c < NCH; c++) begin
            f_act[c]    <= slew(f_act[c], f_tgt[c]);
            q_act[c]    <= slew(q_act[c], q_tgt[c]);
            mode_act[c] <= mode_tgt[c];
          end
          ovf   <= 1'b0;
          ch    <= '0;
          state <= MUL_LP;
        end
        MUL_LP: begin
          lp_n  <= sum_sat;
          ovf   <= ovf | sum_ovf;
          state <= MUL_Q;
        end
        MUL_Q: begin
          hp    <= sum_sat;
          ovf   <= ovf | sum_ovf;
          state <= MUL_BP;
        end
        MUL_BP: begin
          bp_n  <= sum_sat;
          ovf   <= ovf | sum_ovf;
          state <= WB;
        end
        WB: begin
          lp[ch] <= lp_n;
          bp[ch] <= bp_n;
          case (mode_act[ch])
            2'd0: out_buf[ch] <= lp_n;
            2'd1: out_buf[ch] <= bp_n;
            2'd2: out_buf[ch] <= hp;
            default: begin
              out_buf[ch] <= sum_sat;
              ovf         <= ovf | sum_ovf;
            end
          endcase
          if (ch == LAST_CH) begin
            state <= DONE;
          end else begin
            ch    <= ch + CW'(1);
            state <= MUL_LP;
          end
        end
        DONE: begin
          for (int c = 0; c < NCH; c++) sample_out[c*DATA_W +: DATA_W] <= out_buf[c];
          err_overflow   <= ovf;
          sample_out_rdy <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_module_svf_multi.sv
// Bench for module_svf_multi: randomized frames and CC traffic against a frame-level
// reference model of the filter equations, plus directed reset/latency/slew/overflow cases.
`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 4
`endif
`ifndef MIDI_CMD_CC
`define MIDI_CMD_CC 4'hB
`endif

module tb_module_svf_multi;
  localparam int DATA_W = 18;
  localparam int NCH    = 2;
  localparam int CMDW   = `MIDI_CMD_SIZE;
  localparam int S_MAX  = 131071;
  localparam int S_MIN  = -131072;
  typedef logic [CMDW-1:0] cmd_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  midi_rdy;
  cmd_t                  midi_cmd;
  logic [3:0]            midi_ch_sysn;
  logic [6:0]            midi_data0, midi_data1;
  logic                  sample_in_rdy;
  logic [NCH*DATA_W-1:0] sample_in;
  logic                  sample_out_rdy;
  logic [NCH*DATA_W-1:0] sample_out;
  logic                  busy;
  logic                  err_overflow;

  module_svf_multi dut (
    .clk(clk), .reset(reset), .midi_rdy(midi_rdy), .midi_cmd(midi_cmd),
    .midi_ch_sysn(midi_ch_sysn), .midi_data0(midi_data0), .midi_data1(midi_data1),
    .sample_in_rdy(sample_in_rdy), .sample_in(sample_in), .sample_out_rdy(sample_out_rdy),
    .sample_out(sample_out), .busy(busy), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  cmd_t cc_cmd = cmd_t'(`MIDI_CMD_CC);

  // Reference model: per-channel filter state and coefficients as plain integers.
  int  m_lp[NCH], m_bp[NCH], m_fa[NCH], m_qa[NCH], m_ft[NCH], m_qt[NCH], m_mt[NCH], m_ma[NCH];
  bit  m_ovf;
  logic [DATA_W-1:0] exp_q[$];
  bit  exp_ovf;
  int  obs[NCH];
  bit  obs_ovf;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sat_m(input int v);
    if (v > S_MAX) begin m_ovf = 1; return S_MAX; end
    if (v < S_MIN) begin m_ovf = 1; return S_MIN; end
    return v;
  endfunction

  function automatic int mul_m(input int a, input int coef);
    longint p;
    p = longint'(a) * longint'(coef);
    return int'(p >>> 17);
  endfunction

  function automatic int step_m(input int act, input int tgt);
    if (tgt - act > 256) return act + 256;
    if (act - tgt > 256) return act - 256;
    return tgt;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_lp[c] = 0; m_bp[c] = 0; m_fa[c] = 0; m_ft[c] = 0;
      m_qa[c] = 64; m_qt[c] = 64; m_mt[c] = 0; m_ma[c] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_cc(input logic [3:0] mch, input cmd_t cmd, input int d0, input int d1);
    if (cmd == cc_cmd && mch == 4'h0) begin
      if (d0 >= 16 && d0 < 16 + NCH) m_ft[d0-16] = d1 * 512;
      if (d0 >= 24 && d0 < 24 + NCH) m_qt[d0-24] = (d1 * 1024 < 64) ? 64 : d1 * 1024;
      if (d0 >= 32 && d0 < 32 + NCH) m_mt[d0-32] = d1 % 4;
    end
  endtask

  task automatic model_frame(input logic [NCH*DATA_W-1:0] frame);
    int x, lpn, bpn, hpv, o;
    logic [DATA_W-1:0] ov;
    m_ovf = 0;
    for (int c = 0; c < NCH; c++) begin
      m_fa[c] = step_m(m_fa[c], m_ft[c]);
      m_qa[c] = step_m(m_qa[c], m_qt[c]);
      m_ma[c] = m_mt[c];
    end
    for (int c = 0; c < NCH; c++) begin
      x   = int'($signed(frame[c*DATA_W +: DATA_W]));
      lpn = sat_m(m_lp[c] + mul_m(m_bp[c], m_fa[c]));
      hpv = sat_m(x - lpn - mul_m(m_bp[c], m_qa[c]));
      bpn = sat_m(m_bp[c] + mul_m(hpv, m_fa[c]));
      m_lp[c] = lpn;
      m_bp[c] = bpn;
      case (m_ma[c])
        0: o = lpn;
        1: o = bpn;
        2: o = hpv;
        default: o = sat_m(hpv + lpn);
      endcase
      ov = DATA_W'(o);
      exp_q.push_back(ov);
    end
    exp_ovf = m_ovf;
  endtask

  task automatic send_cc(input logic [3:0] mch, input cmd_t cmd, input int d0, input int d1);
    @(posedge clk); #1;
    midi_ch_sysn = mch; midi_cmd = cmd;
    midi_data0 = 7'(d0); midi_data1 = 7'(d1); midi_rdy = 1'b1;
    @(posedge clk); #1;
    midi_rdy = 1'b0;
    model_cc(mch, cmd, d0, d1);
  endtask

  task automatic run_frame(input logic [NCH*DATA_W-1:0] frame, input bit b2b,
                           input bit cc_en, input int cc_d0, input int cc_d1, input bit drop);
    int cnt;
    bit got;
    logic [DATA_W-1:0] e, a;
    if (!b2b) begin
      @(posedge clk); #1;
      chk_cnt++;
      if (sample_out_rdy !== 1'b0 || busy !== 1'b0)
        $display("FAIL idle: sample_out_rdy=%0b busy=%0b, required 0 0", sample_out_rdy, busy);
      else pass_cnt++;
    end
    sample_in = frame; sample_in_rdy = 1'b1;
    @(posedge clk);
    model_frame(frame);
    #1; sample_in_rdy = 1'b0;
    cnt = 0; got = 0;
    while (!got && cnt < 30) begin
      @(posedge clk); cnt++; #1;
      if (cnt == 2 && cc_en) begin
        midi_ch_sysn = 4'h0; midi_cmd = cc_cmd;
        midi_data0 = 7'(cc_d0); midi_data1 = 7'(cc_d1); midi_rdy = 1'b1;
      end
      if (cnt == 3 && cc_en) begin
        midi_rdy = 1'b0;
        model_cc(4'h0, cc_cmd, cc_d0, cc_d1);
      end
      if (cnt == 4 && drop) begin
        sample_in = {$urandom, $urandom}; sample_in_rdy = 1'b1;
      end
      if (cnt == 5) begin
        sample_in_rdy = 1'b0;
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_mid: busy=%0b, required 1", busy);
        else pass_cnt++;
      end
      if (sample_out_rdy === 1'b1) got = 1;
    end
    chk_cnt++;
    if (!got || cnt != 10) $display("FAIL latency: got=%0b cycles=%0d, required 10", got, cnt);
    else pass_cnt++;
    for (int c = 0; c < NCH; c++) begin
      e = exp_q.pop_front();
      a = sample_out[c*DATA_W +: DATA_W];
      obs[c] = int'($signed(a));
      chk_cnt++;
      if (a !== e) $display("FAIL sample_out ch%0d: got %05h, required %05h", c, a, e);
      else pass_cnt++;
    end
    obs_ovf = err_overflow;
    chk_cnt++;
    if (err_overflow !== exp_ovf)
      $display("FAIL err_overflow: got %0b, required %0b", err_overflow, exp_ovf);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b0; midi_rdy = 1'b0; midi_cmd = '0; midi_ch_sysn = '0;
    midi_data0 = '0; midi_data1 = '0; sample_in_rdy = 1'b0; sample_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (sample_out !== '0) $display("FAIL reset_out: got %h, required 0", sample_out); else pass_cnt++;
    chk_cnt++; if (sample_out_rdy !== 1'b0) $display("FAIL reset_rdy: got %0b, required 0", sample_out_rdy); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b, required 0", busy); else pass_cnt++;
    chk_cnt++; if (err_overflow !== 1'b0) $display("FAIL reset_ovf: got %0b, required 0", err_overflow); else pass_cnt++;
    reset = 1'b1;
  endtask

  task automatic test_lp_frozen();
    for (int i = 0; i < 3; i++) begin
      run_frame({18'($urandom), 18'h08000}, 0, 0, 0, 0, 0);
      chk_cnt++;
      if (obs[0] != 0) $display("FAIL lp_frozen: got %0d, required 0", obs[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_slew();
    send_cc(4'h0, cc_cmd, 16, 64);
    for (int i = 0; i < 130; i++) run_frame({18'h00000, 18'h08000}, 0, 0, 0, 0, 0);
  endtask

  task automatic test_converge();
    send_cc(4'h0, cc_cmd, 24, 64);
    for (int i = 0; i < 400; i++) run_frame({18'h00000, 18'h08000}, 0, 0, 0, 0, 0);
    chk_cnt++;
    if (iabs(obs[0] - 32768) > 4) $display("FAIL lp_converge: got %0d, required 32768 +-4", obs[0]);
    else pass_cnt++;
    send_cc(4'h0, cc_cmd, 32, 2);
    for (int i = 0; i < 4; i++) run_frame({18'h00000, 18'h08000}, 0, 0, 0, 0, 0);
    chk_cnt++;
    if (iabs(obs[0]) > 4) $display("FAIL hp_converge: got %0d, required 0 +-4", obs[0]);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    bit seen_ovf;
    int n;
    do_reset();
    send_cc(4'h0, cc_cmd, 32, 1);
    send_cc(4'h0, cc_cmd, 33, 1);
    send_cc(4'h0, cc_cmd, 16, 64);
    send_cc(4'h0, cc_cmd, 17, 64);
    seen_ovf = 0;
    for (int i = 0; i < 160; i++) begin
      run_frame({18'h1FFFF, 18'h1FFFF}, 0, 0, 0, 0, 0);
      if (obs_ovf) seen_ovf = 1;
    end
    chk_cnt++;
    if (!seen_ovf) $display("FAIL overflow_seen: err_overflow never 1, required 1");
    else pass_cnt++;
    send_cc(4'h0, cc_cmd, 24, 127);
    send_cc(4'h0, cc_cmd, 25, 127);
    n = 0;
    do begin
      run_frame('0, 0, 0, 0, 0, 0);
      n++;
    end while (obs_ovf && n < 900);
    chk_cnt++;
    if (obs_ovf) $display("FAIL overflow_clear: err_overflow=%0b after %0d frames, required 0", obs_ovf, n);
    else pass_cnt++;
  endtask

  task automatic test_busy_midframe_cc();
    send_cc(4'h0, cc_cmd, 32, 0);
    send_cc(4'h0, cc_cmd, 33, 0);
    run_frame({18'h01000, 18'h04000}, 0, 0, 0, 0, 0);
    run_frame({18'h01000, 18'h04000}, 0, 1, 32, 2, 1);
    run_frame({18'h01000, 18'h04000}, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_frame({18'h3F000, 18'h02000}, 0, 0, 0, 0, 0);
    run_frame({18'h00400, 18'h3C000}, 1, 0, 0, 0, 0);
    run_frame({18'h12345, 18'h2ABCD}, 1, 1, 17, 90, 0);
  endtask

  task automatic test_midframe_reset();
    bit seen;
    @(posedge clk); #1;
    sample_in = {18'h0A000, 18'h0A000}; sample_in_rdy = 1'b1;
    @(posedge clk); #1;
    sample_in_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (sample_out_rdy === 1'b1) seen = 1;
    end
    chk_cnt++; if (seen) $display("FAIL abort_rdy: sample_out_rdy seen 1, required 0"); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %0b, required 0", busy); else pass_cnt++;
    chk_cnt++; if (sample_out !== '0) $display("FAIL abort_out: got %h, required 0", sample_out); else pass_cnt++;
    send_cc(4'h0, cc_cmd, 16, 100);
    run_frame({18'h05000, 18'h3B000}, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int ncc, d0, d1, pick;
    int cc_list[10] = '{16, 17, 18, 24, 25, 26, 32, 33, 34, 5};
    logic [3:0] mch;
    cmd_t cmd;
    for (int i = 0; i < 60; i++) begin
      ncc = $urandom_range(0, 2);
      for (int k = 0; k < ncc; k++) begin
        pick = $urandom_range(0, 9);
        d0   = cc_list[pick];
        d1   = $urandom_range(0, 127);
        mch  = ($urandom_range(0, 7) == 0) ? 4'h3 : 4'h0;
        cmd  = ($urandom_range(0, 7) == 0) ? (cc_cmd ^ cmd_t'(1)) : cc_cmd;
        send_cc(mch, cmd, d0, d1);
      end
      pick = $urandom_range(0, 9);
      run_frame({18'($urandom), 18'($urandom)}, bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), cc_list[pick], $urandom_range(0, 127),
                bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_lp_frozen();
    test_slew();
    test_converge();
    test_overflow();
    test_busy_midframe_cc();
    test_back_to_back();
    test_midframe_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
